// File: rtl/kme_ib_arbiter.sv
// kme_ib_arbiter: frame-level round-robin arbiter for the KME inbound AXI-stream port.
// One requester owns the port from its SoT beat through its EoT beat, so frames never
// interleave. Framing violations from the owner set a sticky error flag.
// Optional per-requester completed-frame counters are built when KME_IB_ARB_STATS_EN
// is defined; without it the arbitration behaviour is identical.
module kme_ib_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_tvalid,
    output logic [N_REQ-1:0]        req_tready,
    input  logic [N_REQ*DATA_W-1:0] req_tdata,
    input  logic [N_REQ*8-1:0]      req_tstrb,
    input  logic [N_REQ*8-1:0]      req_tuser,
    output logic                    ib_tvalid,
    input  logic                    ib_tready,
    output logic [DATA_W-1:0]       ib_tdata,
    output logic [7:0]              ib_tstrb,
    output logic [7:0]              ib_tuser,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
`ifdef KME_IB_ARB_STATS_EN
    input  logic                    stats_clr,
    output logic [N_REQ*CNT_W-1:0]  frm_cnt,
`endif
    output logic                    frm_err
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [PtrW-1:0]  owner_q;
    logic [PtrW-1:0]  rr_ptr_q;
    logic             first_q;   // next accepted beat is the first of this grant
    logic             frm_err_q;

    logic [PtrW:0]    cand;
    logic [PtrW-1:0]  win_idx;
    logic             win_found;
    logic [PtrW-1:0]  owner_inc;
    logic             beat_xfer;
    logic             beat_sot;
    logic             beat_eot;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
            if (cand >= (PtrW+1)'(N_REQ)) begin
                cand = cand - (PtrW+1)'(N_REQ);
            end
            if (!win_found && req_tvalid[cand[PtrW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PtrW-1:0];
            end
        end
    end

    // Route the owner's channel straight to the inbound port; ready returns to the owner only.
    always_comb begin
        req_tready = '0;
        ib_tvalid  = 1'b0;
        ib_tdata   = '0;
        ib_tstrb   = '0;
        ib_tuser   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == PtrW'(i)) begin
                ib_tdata = req_tdata[i*DATA_W +: DATA_W];
                ib_tstrb = req_tstrb[i*8 +: 8];
                ib_tuser = req_tuser[i*8 +: 8];
            end
        end
        if (state_q == StXfer) begin
            ib_tvalid           = req_tvalid[owner_q];
            req_tready[owner_q] = ib_tready;
        end
    end

    assign beat_xfer = ib_tvalid && ib_tready;
    assign beat_sot  = ib_tuser[0];
    assign beat_eot  = ib_tuser[1];
    assign owner_inc = (owner_q == PtrW'(N_REQ - 1)) ? '0 : owner_q + PtrW'(1);

    // Arbitration FSM: grant from IDLE, hold through EoT, check framing on accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            first_q   <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        state_q <= StXfer;
                        grant_q <= N_REQ'(1) << win_idx;
                        owner_q <= win_idx;
                        first_q <= 1'b1;
                    end
                end
                StXfer: begin
                    if (beat_xfer) begin
                        first_q <= 1'b0;
                        // SoT must appear on the first beat of a grant and on no other.
                        if (first_q != beat_sot) begin
                            frm_err_q <= 1'b1;
                        end
                        if (beat_eot) begin
                            state_q  <= StIdle;
                            grant_q  <= '0;
                            rr_ptr_q <= owner_inc;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q == StXfer);
    assign frm_err = frm_err_q;

`ifdef KME_IB_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    // Completed-frame counters; a clear in the same cycle as an EoT wins.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (beat_xfer && beat_eot) begin
            cnt_q[owner_q] <= cnt_q[owner_q] + CNT_W'(1);
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        frm_cnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            frm_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule
